// File: rtl/mult_pkg.sv
// Shared definitions for the sequential multiplier.
//   state_e         : controller states (IDLE, BUSY, DONE)
//   LEGAL_BPC_MASK  : bit n set means BITS_PER_CYCLE = n is supported
//   iter_count()    : iterations per operation, WIDTH / BITS_PER_CYCLE
//   cnt_width()     : iteration counter width, clog2(ITER + 1)
//   bpc_is_legal()  : checks a BITS_PER_CYCLE value against LEGAL_BPC_MASK
package mult_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Supported values are 1, 2 and 4.
  localparam logic [4:0] LEGAL_BPC_MASK = 5'b1_0110;

  function automatic int iter_count(input int width, input int bpc);
    return width / bpc;
  endfunction

  function automatic int cnt_width(input int width, input int bpc);
    return $clog2(iter_count(width, bpc) + 1);
  endfunction

  function automatic bit bpc_is_legal(input int bpc);
    if (bpc < 1 || bpc > 4) return 1'b0;
    return LEGAL_BPC_MASK[bpc];
  endfunction

endpackage

// File: rtl/mult_pp_step.sv
// One multiply iteration: forms mcand x (BITS_PER_CYCLE multiplier bits),
// aligns it to the current iteration and adds it to the accumulator.
// Purely combinational.
//   i_acc         : accumulator before this iteration (2*WIDTH bits)
//   i_mcand       : multiplicand magnitude (WIDTH bits)
//   i_mplier_bits : low multiplier bits consumed this iteration
//   i_cnt         : iteration index, selects the alignment shift
//   o_acc         : accumulator after this iteration
module mult_pp_step
  import mult_pkg::*;
#(
  parameter int WIDTH          = 32,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic [2*WIDTH-1:0]                            i_acc,
  input  logic [WIDTH-1:0]                              i_mcand,
  input  logic [BITS_PER_CYCLE-1:0]                     i_mplier_bits,
  input  logic [cnt_width(WIDTH, BITS_PER_CYCLE)-1:0]   i_cnt,
  output logic [2*WIDTH-1:0]                            o_acc
);

  localparam int PW    = 2 * WIDTH;
  localparam int CNT_W = cnt_width(WIDTH, BITS_PER_CYCLE);
  // Three spare bits cover the multiply by BITS_PER_CYCLE <= 4.
  localparam int SH_W  = CNT_W + 3;

  logic [PW-1:0]   w_pp;
  logic [SH_W-1:0] w_shamt;

  assign w_pp    = PW'(i_mcand) * PW'(i_mplier_bits);
  assign w_shamt = SH_W'(i_cnt) * SH_W'(BITS_PER_CYCLE);
  assign o_acc   = i_acc + (w_pp << w_shamt);

endmodule

// File: rtl/mult_seq_nbits.sv
// Sequential WIDTH x WIDTH multiplier, unsigned or two's-complement per
// operation, retiring BITS_PER_CYCLE multiplier bits per clock.
// Operands enter through a valid/ready handshake; the 2*WIDTH-bit product
// leaves through another. Sign is handled by multiplying magnitudes and
// negating the result when the operand signs differ.
//   clk, rst_n          : clock, synchronous active-low reset
//   in_valid / in_ready : operand handshake (in_ready = IDLE)
//   mplier, mcand       : operands, sampled only on the accept edge
//   is_signed           : 1 = two's-complement operands, 0 = unsigned
//   out_valid/out_ready : result handshake (out_valid = DONE)
//   product             : registered result, held until the next result
module mult_seq_nbits
  import mult_pkg::*;
#(
  parameter int WIDTH          = 32,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   mplier,
  input  logic [WIDTH-1:0]   mcand,
  input  logic               is_signed,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] product
);

  localparam int PW    = 2 * WIDTH;
  localparam int ITER  = iter_count(WIDTH, BITS_PER_CYCLE);
  localparam int CNT_W = cnt_width(WIDTH, BITS_PER_CYCLE);

  if (WIDTH < 2) begin : g_bad_width
    $error("mult_seq_nbits: WIDTH must be at least 2");
  end
  if (!bpc_is_legal(BITS_PER_CYCLE)) begin : g_bad_bpc
    $error("mult_seq_nbits: BITS_PER_CYCLE must be 1, 2 or 4");
  end
  if ((WIDTH % BITS_PER_CYCLE) != 0) begin : g_bad_div
    $error("mult_seq_nbits: BITS_PER_CYCLE must divide WIDTH");
  end

  state_e           r_state;
  state_e           w_next_state;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_mplier;
  logic [WIDTH-1:0] r_mcand;
  logic             r_neg;
  logic [PW-1:0]    r_acc;
  logic [PW-1:0]    r_product;

  logic             w_accept;
  logic             w_last;
  logic [WIDTH-1:0] w_mplier_mag;
  logic [WIDTH-1:0] w_mcand_mag;
  logic [PW-1:0]    w_acc_next;

  // Negating the most-negative value wraps back to 2^(WIDTH-1), which is
  // exactly the magnitude wanted when read as unsigned.
  assign w_mplier_mag = (is_signed && mplier[WIDTH-1]) ? -mplier : mplier;
  assign w_mcand_mag  = (is_signed && mcand[WIDTH-1])  ? -mcand  : mcand;

  assign w_accept = in_valid && (r_state == ST_IDLE);
  assign w_last   = (r_state == ST_BUSY) && (r_cnt == CNT_W'(ITER - 1));

  mult_pp_step #(
    .WIDTH          (WIDTH),
    .BITS_PER_CYCLE (BITS_PER_CYCLE)
  ) u_step (
    .i_acc         (r_acc),
    .i_mcand       (r_mcand),
    .i_mplier_bits (r_mplier[BITS_PER_CYCLE-1:0]),
    .i_cnt         (r_cnt),
    .o_acc         (w_acc_next)
  );

  // NOTE: reset is synchronous, so rst_n is tested inside the clocked block
  // and does not appear in the sensitivity list.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Handshake outputs are decoded from state only, so there is no
  // combinational path from in_valid or out_ready.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path
    // leaves a variable unassigned and no latch is inferred.
    w_next_state = r_state;
    in_ready     = 1'b0;
    out_valid    = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) w_next_state = ST_BUSY;
      end
      ST_BUSY: begin
        if (w_last) w_next_state = ST_DONE;
      end
      ST_DONE: begin
        out_valid = 1'b1;
        if (out_ready) w_next_state = ST_IDLE;
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt     <= '0;
      r_mplier  <= '0;
      r_mcand   <= '0;
      r_neg     <= 1'b0;
      r_acc     <= '0;
      r_product <= '0;
    end else if (w_accept) begin
      // NOTE: non-blocking assignments so every register here sees the
      // pre-edge values of the others, independent of statement order.
      r_mplier <= w_mplier_mag;
      r_mcand  <= w_mcand_mag;
      r_neg    <= is_signed & (mplier[WIDTH-1] ^ mcand[WIDTH-1]);
      r_acc    <= '0;
      r_cnt    <= '0;
    end else if (r_state == ST_BUSY) begin
      r_acc    <= w_acc_next;
      r_mplier <= r_mplier >> BITS_PER_CYCLE;
      r_cnt    <= r_cnt + CNT_W'(1);
      // Product only changes here, so it stays stable through DONE and
      // after the output handshake.
      if (w_last) r_product <= r_neg ? -w_acc_next : w_acc_next;
    end
  end

  assign product = r_product;

endmodule

// File: tb/tb_mult_seq_nbits.sv
// Self-checking bench for mult_seq_nbits. Five instances share one clock
// and reset:
//   k=0 WIDTH=32 BPC=1   k=1 WIDTH=8 BPC=1
//   k=2 WIDTH=16 BPC=1   k=3 WIDTH=16 BPC=2   k=4 WIDTH=16 BPC=4
module tb_mult_seq_nbits;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        in_valid_a  [5];
  logic        in_ready_a  [5];
  logic        out_valid_a [5];
  logic        out_ready_a [5];
  logic        is_signed_a [5];
  logic [31:0] mplier_a    [5];
  logic [31:0] mcand_a     [5];
  logic [63:0] prod_a      [5];

  logic [63:0] p0;
  logic [15:0] p1;
  logic [31:0] p2, p3, p4;

  always_comb begin
    prod_a[0] = p0;
    prod_a[1] = {48'd0, p1};
    prod_a[2] = {32'd0, p2};
    prod_a[3] = {32'd0, p3};
    prod_a[4] = {32'd0, p4};
  end

  mult_seq_nbits #(.WIDTH(32), .BITS_PER_CYCLE(1)) dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_a[0]), .in_ready(in_ready_a[0]),
    .mplier(mplier_a[0]), .mcand(mcand_a[0]), .is_signed(is_signed_a[0]),
    .out_valid(out_valid_a[0]), .out_ready(out_ready_a[0]), .product(p0));

  mult_seq_nbits #(.WIDTH(8), .BITS_PER_CYCLE(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_a[1]), .in_ready(in_ready_a[1]),
    .mplier(mplier_a[1][7:0]), .mcand(mcand_a[1][7:0]), .is_signed(is_signed_a[1]),
    .out_valid(out_valid_a[1]), .out_ready(out_ready_a[1]), .product(p1));

  mult_seq_nbits #(.WIDTH(16), .BITS_PER_CYCLE(1)) dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_a[2]), .in_ready(in_ready_a[2]),
    .mplier(mplier_a[2][15:0]), .mcand(mcand_a[2][15:0]), .is_signed(is_signed_a[2]),
    .out_valid(out_valid_a[2]), .out_ready(out_ready_a[2]), .product(p2));

  mult_seq_nbits #(.WIDTH(16), .BITS_PER_CYCLE(2)) dut3 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_a[3]), .in_ready(in_ready_a[3]),
    .mplier(mplier_a[3][15:0]), .mcand(mcand_a[3][15:0]), .is_signed(is_signed_a[3]),
    .out_valid(out_valid_a[3]), .out_ready(out_ready_a[3]), .product(p3));

  mult_seq_nbits #(.WIDTH(16), .BITS_PER_CYCLE(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_a[4]), .in_ready(in_ready_a[4]),
    .mplier(mplier_a[4][15:0]), .mcand(mcand_a[4][15:0]), .is_signed(is_signed_a[4]),
    .out_valid(out_valid_a[4]), .out_ready(out_ready_a[4]), .product(p4));

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic int iter_of(input int k);
    case (k)
      0:       return 32;
      1:       return 8;
      2:       return 16;
      3:       return 8;
      default: return 4;
    endcase
  endfunction

  function automatic logic [31:0] ref_mul16(input logic [15:0] a, input logic [15:0] b,
                                            input logic s);
    longint sa, sb;
    sa = s ? longint'($signed(a)) : longint'(a);
    sb = s ? longint'($signed(b)) : longint'(b);
    return 32'(sa * sb);
  endfunction

  // Called at a negedge; returns at the negedge after the output handshake.
  task automatic do_op(input int k, input logic [31:0] a, input logic [31:0] b,
                       input logic s, input logic [63:0] exp, input string name);
    int n;
    n = 0;
    while (!in_ready_a[k] && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready_a[k]) begin
      check({name, " in_ready timeout"}, 64'(in_ready_a[k]), 64'd1);
      return;
    end
    mplier_a[k] = a; mcand_a[k] = b; is_signed_a[k] = s; in_valid_a[k] = 1'b1;
    @(negedge clk);
    // Scramble operands after accept: they must have no effect.
    in_valid_a[k] = 1'b0; mplier_a[k] = ~a; mcand_a[k] = ~b; is_signed_a[k] = ~s;
    n = 1;
    while (!out_valid_a[k] && n < 200) begin
      @(negedge clk);
      n++;
    end
    check({name, " latency"}, 64'(n), 64'(iter_of(k) + 1));
    check({name, " product"}, prod_a[k], exp);
    out_ready_a[k] = 1'b1;
    @(negedge clk);
    out_ready_a[k] = 1'b0;
    check({name, " in_ready after handshake"}, 64'(in_ready_a[k]), 64'd1);
  endtask

  typedef struct {
    int          k;
    logic [31:0] a;
    logic [31:0] b;
    logic        s;
    logic [63:0] exp;
  } vec_t;

  vec_t vecs [11];

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] ra, rb;
    logic        rs;
    logic [63:0] rexp;
    int          acc_cyc [$];
    logic [63:0] got [$];
    logic [15:0] sa [4];
    logic [15:0] sb [4];
    int          idx, t;

    vecs[0]  = '{0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 64'hFFFF_FFFE_0000_0001};
    vecs[1]  = '{0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 64'h0000_0000_0000_0001};
    vecs[2]  = '{0, 32'h8000_0000, 32'h8000_0000, 1'b1, 64'h4000_0000_0000_0000};
    vecs[3]  = '{0, 32'h0000_0007, 32'hFFFF_FFFD, 1'b1, 64'hFFFF_FFFF_FFFF_FFEB};
    vecs[4]  = '{0, 32'h0000_0000, 32'h1234_5678, 1'b0, 64'h0};
    vecs[5]  = '{1, 32'h80, 32'h80, 1'b1, 64'h4000};
    vecs[6]  = '{1, 32'h80, 32'h7F, 1'b1, 64'hC080};
    vecs[7]  = '{1, 32'hFF, 32'h01, 1'b1, 64'hFFFF};
    vecs[8]  = '{1, 32'hFF, 32'h01, 1'b0, 64'h00FF};
    vecs[9]  = '{1, 32'hFF, 32'hFF, 1'b0, 64'hFE01};
    vecs[10] = '{4, 32'h8000, 32'hFFFF, 1'b1, 64'h8000};

    for (int k = 0; k < 5; k++) begin
      in_valid_a[k] = 1'b0; out_ready_a[k] = 1'b0; is_signed_a[k] = 1'b0;
      mplier_a[k] = '0; mcand_a[k] = '0;
    end

    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      check($sformatf("reset in_ready k%0d", k), 64'(in_ready_a[k]), 64'd1);
      check($sformatf("reset out_valid k%0d", k), 64'(out_valid_a[k]), 64'd0);
      check($sformatf("reset product k%0d", k), prod_a[k], 64'd0);
    end

    // Directed table.
    for (int i = 0; i < 11; i++)
      do_op(vecs[i].k, vecs[i].a, vecs[i].b, vecs[i].s, vecs[i].exp, $sformatf("vec%0d", i));

    // Back-pressure on the 8-bit instance.
    do_op(1, 32'h0, 32'h0, 1'b0, 64'h0, "bp warmup");
    mplier_a[1] = 32'h05; mcand_a[1] = 32'h06; is_signed_a[1] = 1'b0; in_valid_a[1] = 1'b1;
    @(negedge clk);
    in_valid_a[1] = 1'b0;
    t = 0;
    while (!out_valid_a[1] && t < 50) begin
      @(negedge clk);
      t++;
    end
    mplier_a[1] = 32'h7F; mcand_a[1] = 32'h7F; in_valid_a[1] = 1'b1;
    for (int c = 0; c < 20; c++) begin
      check($sformatf("bp out_valid c%0d", c), 64'(out_valid_a[1]), 64'd1);
      check($sformatf("bp product c%0d", c), prod_a[1], 64'h1E);
      check($sformatf("bp in_ready c%0d", c), 64'(in_ready_a[1]), 64'd0);
      @(negedge clk);
    end
    in_valid_a[1] = 1'b0; out_ready_a[1] = 1'b1;
    @(negedge clk);
    out_ready_a[1] = 1'b0;
    check("bp in_ready after handshake", 64'(in_ready_a[1]), 64'd1);
    check("bp out_valid after handshake", 64'(out_valid_a[1]), 64'd0);
    check("bp product held", prod_a[1], 64'h1E);
    repeat (3) @(negedge clk);
    check("bp still idle", 64'(in_ready_a[1]), 64'd1);

    // Reset in the middle of BUSY on the 32-bit instance.
    mplier_a[0] = 32'hFFFF_FFFF; mcand_a[0] = 32'h2; is_signed_a[0] = 1'b0; in_valid_a[0] = 1'b1;
    @(negedge clk);
    in_valid_a[0] = 1'b0;
    repeat (9) @(negedge clk);
    check("mid-busy in_ready before reset", 64'(in_ready_a[0]), 64'd0);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("reset mid-busy out_valid", 64'(out_valid_a[0]), 64'd0);
    check("reset mid-busy product", prod_a[0], 64'd0);
    check("reset mid-busy in_ready", 64'(in_ready_a[0]), 64'd1);
    do_op(0, 32'd3, 32'd5, 1'b0, 64'd15, "after reset 3x5");

    // Random sweep: the three 16-bit configurations run side by side.
    for (int i = 0; i < 1000; i++) begin
      ra = {16'd0, 16'($urandom)};
      rb = {16'd0, 16'($urandom)};
      rs = 1'($urandom_range(0, 1));
      rexp = {32'd0, ref_mul16(ra[15:0], rb[15:0], rs)};
      fork
        do_op(2, ra, rb, rs, rexp, $sformatf("rnd%0d bpc1", i));
        do_op(3, ra, rb, rs, rexp, $sformatf("rnd%0d bpc2", i));
        do_op(4, ra, rb, rs, rexp, $sformatf("rnd%0d bpc4", i));
      join
    end

    // Back-to-back streaming on the 16-bit, 1 bit/cycle instance.
    sa = '{16'd3, 16'hFFFF, 16'h1234, 16'h0};
    sb = '{16'd5, 16'hFFFF, 16'h0010, 16'hABCD};
    idx = 0; t = 0;
    is_signed_a[2] = 1'b0; out_ready_a[2] = 1'b1;
    mplier_a[2] = {16'd0, sa[0]}; mcand_a[2] = {16'd0, sb[0]}; in_valid_a[2] = 1'b1;
    while (got.size() < 4 && t < 300) begin
      if (in_ready_a[2] && idx < 4) begin
        acc_cyc.push_back(cyc);
        idx++;
      end
      if (out_valid_a[2]) got.push_back(prod_a[2]);
      @(negedge clk);
      t++;
      if (idx < 4) begin
        mplier_a[2] = {16'd0, sa[idx]}; mcand_a[2] = {16'd0, sb[idx]};
      end else begin
        in_valid_a[2] = 1'b0;
      end
    end
    in_valid_a[2] = 1'b0; out_ready_a[2] = 1'b0;
    check("stream accept count", 64'(acc_cyc.size()), 64'd4);
    check("stream result count", 64'(got.size()), 64'd4);
    for (int i = 1; i < 4; i++)
      if (i < acc_cyc.size())
        check($sformatf("stream spacing %0d", i), 64'(acc_cyc[i] - acc_cyc[i-1]), 64'd18);
    for (int i = 0; i < 4; i++)
      if (i < got.size())
        check($sformatf("stream result %0d", i), got[i], {32'd0, ref_mul16(sa[i], sb[i], 1'b0)});

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
